// File: rtl/mem_tid_arbiter.sv
// mem_tid_arbiter
//   Arbitrates NR_PORTS requesters (load unit, store buffer, PTW) onto a
//   single memory request channel. Each issued request (read or write)
//   is tagged with a transaction ID from a pool of 2**TID_WIDTH IDs. The
//   memory response carries the TID back, and the arbiter routes it to the
//   port that owns that TID.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : per-port request handshake (one bit per port)
//   req_addr_i/we_i/wdata : per-port payload, port i in slice i
//   mem_req_*             : registered memory request (valid/ready, addr,
//                           we, wdata, tid)
//   mem_rsp_*             : memory response (valid, tid, rdata), no stall
//   rsp_valid_o/rdata_o   : response routed to the owning port
//   outstanding_o         : number of TIDs currently in use
//   err_o                 : sticky, set by a response to a TID not in use
module mem_tid_arbiter #(
  parameter int NR_PORTS   = 3,
  parameter int TID_WIDTH  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_PORTS-1:0]            req_valid_i,
  output logic [NR_PORTS-1:0]            req_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NR_PORTS-1:0]            req_we_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
  output logic                           mem_req_we_o,
  output logic [DATA_WIDTH-1:0]          mem_req_wdata_o,
  output logic [TID_WIDTH-1:0]           mem_req_tid_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [TID_WIDTH-1:0]           mem_rsp_tid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rsp_rdata_i,
  output logic [NR_PORTS-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic [TID_WIDTH:0]             outstanding_o,
  output logic                           err_o
);

  localparam int NUM_TIDS = 2**TID_WIDTH;
  localparam int PW       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef enum logic {EMPTY, FULL} stage_state_t;

  // State
  stage_state_t          state_reg;
  logic [NUM_TIDS-1:0]   free_reg;
  logic [PW-1:0]         owner_reg [NUM_TIDS];
  logic [PW-1:0]         rr_ptr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [TID_WIDTH-1:0]  tid_reg;
  logic                  err_reg;
  logic [TID_WIDTH:0]    outstanding_reg;

  // Combinational decisions
  logic                  stage_avail;
  logic                  any_free;
  logic                  cand_valid;
  logic [PW-1:0]         grant_idx;
  logic                  grant;
  logic [TID_WIDTH-1:0]  alloc_tid;
  logic                  rsp_hit;
  logic                  rsp_bogus;
  logic [PW-1:0]         rsp_owner;
  int                    scan_idx;

  // The stage can take a new request if it is empty, or if its current
  // content is being accepted by memory this very cycle.
  assign stage_avail = (state_reg == EMPTY) || mem_req_ready_i;
  // Only TIDs free at the start of the cycle count; a TID released by a
  // response this cycle is not visible here until the next cycle.
  assign any_free    = |free_reg;

  // Round-robin scan starting at rr_ptr_reg, wrapping modulo NR_PORTS.
  always_comb begin
    cand_valid = 1'b0;
    grant_idx  = '0;
    scan_idx   = 0;
    for (int k = 0; k < NR_PORTS; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NR_PORTS) begin
        scan_idx = scan_idx - NR_PORTS;
      end
      if (!cand_valid && req_valid_i[PW'(scan_idx)]) begin
        cand_valid = 1'b1;
        grant_idx  = PW'(scan_idx);
      end
    end
  end

  assign grant = cand_valid && stage_avail && any_free && !rst_i;

  // Lowest-index free TID: scan downward so the last hit is the lowest.
  always_comb begin
    alloc_tid = '0;
    for (int t = NUM_TIDS - 1; t >= 0; t--) begin
      if (free_reg[TID_WIDTH'(t)]) begin
        alloc_tid = TID_WIDTH'(t);
      end
    end
  end

  assign rsp_hit   = mem_rsp_valid_i && !free_reg[mem_rsp_tid_i];
  assign rsp_bogus = mem_rsp_valid_i &&  free_reg[mem_rsp_tid_i];
  assign rsp_owner = owner_reg[mem_rsp_tid_i];

  generate
    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
      assign req_ready_o[gi] = grant && (grant_idx == PW'(gi));
      assign rsp_valid_o[gi] = rsp_hit && !rst_i && (rsp_owner == PW'(gi));
    end
  endgenerate

  assign rsp_rdata_o     = mem_rsp_rdata_i;
  assign mem_req_valid_o = (state_reg == FULL);
  assign mem_req_addr_o  = addr_reg;
  assign mem_req_we_o    = we_reg;
  assign mem_req_wdata_o = wdata_reg;
  assign mem_req_tid_o   = tid_reg;
  assign outstanding_o   = outstanding_reg;
  assign err_o           = err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= EMPTY;
      free_reg        <= '1;
      rr_ptr_reg      <= '0;
      addr_reg        <= '0;
      we_reg          <= 1'b0;
      wdata_reg       <= '0;
      tid_reg         <= '0;
      err_reg         <= 1'b0;
      outstanding_reg <= '0;
      for (int t = 0; t < NUM_TIDS; t++) begin
        owner_reg[t] <= '0;
      end
    end else begin
      // A response frees an in-use TID while a grant takes a TID that was
      // free, so the two bit updates never touch the same entry.
      if (rsp_hit) begin
        free_reg[mem_rsp_tid_i] <= 1'b1;
      end
      if (rsp_bogus) begin
        err_reg <= 1'b1;
      end

      case ({grant, rsp_hit})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase

      if (grant) begin
        free_reg[alloc_tid]  <= 1'b0;
        owner_reg[alloc_tid] <= grant_idx;
        state_reg            <= FULL;
        addr_reg             <= req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        we_reg               <= req_we_i[grant_idx];
        wdata_reg            <= req_wdata_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        tid_reg              <= alloc_tid;
        if (int'(grant_idx) == NR_PORTS - 1) begin
          rr_ptr_reg <= '0;
        end else begin
          rr_ptr_reg <= grant_idx + 1'b1;
        end
      end else if (state_reg == FULL && mem_req_ready_i) begin
        // Accepted and nothing new to load: payload is left as is.
        state_reg <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mem_tid_arbiter.sv
// tb_mem_tid_arbiter
//   Directed stimulus for mem_tid_arbiter (single request, fairness, TID
//   exhaustion, backpressure, bogus response, reset mid-flight) with
//   literal expectations, plus a per-cycle comparison against a
//   behavioural model of the TID pool, owner table and output stage.
module tb_mem_tid_arbiter;

  localparam int NP = 3;
  localparam int TW = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NT = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_ready_o;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP-1:0]     req_we_i;
  logic [NP*DW-1:0]  req_wdata_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [AW-1:0]     mem_req_addr_o;
  logic              mem_req_we_o;
  logic [DW-1:0]     mem_req_wdata_o;
  logic [TW-1:0]     mem_req_tid_o;
  logic              mem_rsp_valid_i;
  logic [TW-1:0]     mem_rsp_tid_i;
  logic [DW-1:0]     mem_rsp_rdata_i;
  logic [NP-1:0]     rsp_valid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic [TW:0]       outstanding_o;
  logic              err_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  mem_tid_arbiter #(
    .NR_PORTS(NP), .TID_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_tid_o(mem_req_tid_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i),
    .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: a set of in-use TIDs with their owners, a
  // one-entry output slot, a round-robin pointer and the error flag.
  bit          m_used  [NT];
  int          m_owner [NT];
  int          m_rr    = 0;
  bit          m_full  = 1'b0;
  bit [AW-1:0] m_addr  = '0;
  bit          m_we    = 1'b0;
  bit [DW-1:0] m_wdata = '0;
  int          m_tid   = 0;
  bit          m_err   = 1'b0;

  always @(negedge clk) begin
    int grant;
    int alloc;
    int nused;
    logic [NP-1:0] e_ready;
    logic [NP-1:0] e_rsp;
    if (model_on) begin
      e_ready = '0;
      e_rsp   = '0;
      grant   = -1;
      alloc   = -1;
      nused   = 0;
      for (int t = 0; t < NT; t++) if (m_used[t]) nused++;
      for (int t = NT - 1; t >= 0; t--) if (!m_used[t]) alloc = t;
      if (!rst_i) begin
        if ((!m_full || mem_req_ready_i) && nused < NT) begin
          for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_rr + k) % NP;
            if (grant < 0 && req_valid_i[p]) grant = p;
          end
        end
        if (grant >= 0) e_ready[grant] = 1'b1;
        if (mem_rsp_valid_i && m_used[mem_rsp_tid_i]) e_rsp[m_owner[mem_rsp_tid_i]] = 1'b1;
      end

      chk("m_req_ready", req_ready_o, e_ready);
      chk("m_rsp_valid", rsp_valid_o, e_rsp);
      if (e_rsp != '0) chk("m_rsp_rdata", rsp_rdata_o, mem_rsp_rdata_i);
      chk("m_mem_valid", mem_req_valid_o, m_full);
      if (m_full) begin
        chk("m_mem_addr", mem_req_addr_o, m_addr);
        chk("m_mem_we", mem_req_we_o, m_we);
        chk("m_mem_wdata", mem_req_wdata_o, m_wdata);
        chk("m_mem_tid", mem_req_tid_o, m_tid);
      end
      chk("m_outstanding", outstanding_o, nused);
      chk("m_err", err_o, m_err);

      // Advance to the state after the coming rising edge.
      if (rst_i) begin
        for (int t = 0; t < NT; t++) m_used[t] = 1'b0;
        m_rr = 0; m_full = 1'b0; m_addr = '0; m_we = 1'b0;
        m_wdata = '0; m_tid = 0; m_err = 1'b0;
      end else begin
        if (mem_rsp_valid_i) begin
          if (m_used[mem_rsp_tid_i]) m_used[mem_rsp_tid_i] = 1'b0;
          else m_err = 1'b1;
        end
        if (grant >= 0) begin
          m_used[alloc]  = 1'b1;
          m_owner[alloc] = grant;
          m_full  = 1'b1;
          m_addr  = req_addr_i[grant*AW +: AW];
          m_we    = req_we_i[grant];
          m_wdata = req_wdata_i[grant*DW +: DW];
          m_tid   = alloc;
          m_rr    = (grant + 1) % NP;
        end else if (m_full && mem_req_ready_i) begin
          m_full = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NP-1:0] exp_order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    rst_i = 1'b1; req_valid_i = 3'b111; req_addr_i = '0; req_we_i = '0;
    req_wdata_i = '0; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    mem_rsp_tid_i = '0; mem_rsp_rdata_i = '0;
    tick();
    model_on = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", mem_req_valid_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_addr", mem_req_addr_o, 0);
    tick();

    // Single read from port 1
    rst_i = 1'b0; req_valid_i = 3'b010; req_addr_i[AW +: AW] = 64'h8000_0000;
    mem_req_ready_i = 1'b1;
    #1 chk("single_ready", req_ready_o, 3'b010);
    tick();
    req_valid_i = '0;
    chk("single_valid", mem_req_valid_o, 1);
    chk("single_tid", mem_req_tid_o, 0);
    chk("single_addr", mem_req_addr_o, 64'h8000_0000);
    chk("single_outstanding", outstanding_o, 1);
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd0; mem_rsp_rdata_i = 64'hA5;
    #1 chk("single_rsp_valid", rsp_valid_o, 3'b010);
    chk("single_rsp_rdata", rsp_rdata_o, 64'hA5);
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("single_done_outstanding", outstanding_o, 0);
    chk("single_done_valid", mem_req_valid_o, 0);

    // Fairness: all ports valid, immediate responses
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req_valid_i = 3'b111;
    for (int p = 0; p < NP; p++) req_addr_i[p*AW +: AW] = 64'h1000 * (p + 1);
    for (int i = 0; i < 6; i++) begin
      mem_rsp_valid_i = mem_req_valid_o;
      mem_rsp_tid_i   = mem_req_tid_o;
      mem_rsp_rdata_i = 64'h100 + 64'(i);
      #1 chk("fair_grant", req_ready_o, exp_order[i]);
      tick();
    end
    req_valid_i = '0; mem_rsp_valid_i = 1'b0;

    // TID exhaustion
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req_valid_i = 3'b001;
    repeat (4) tick();
    chk("exh_outstanding", outstanding_o, 4);
    chk("exh_last_tid", mem_req_tid_o, 3);
    #1 chk("exh_stall", req_ready_o, 0);
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd2; mem_rsp_rdata_i = 64'h22;
    #1 chk("exh_rsp_valid", rsp_valid_o, 3'b001);
    chk("exh_no_same_cycle_reuse", req_ready_o, 0);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1 chk("exh_regrant", req_ready_o, 3'b001);
    chk("exh_outstanding_3", outstanding_o, 3);
    tick();
    req_valid_i = '0;
    chk("exh_reuse_tid", mem_req_tid_o, 2);
    chk("exh_outstanding_4", outstanding_o, 4);

    // Backpressure: write from port 2
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req_valid_i = 3'b100; req_addr_i[2*AW +: AW] = 64'h1234; req_we_i = 3'b100;
    req_wdata_i[2*DW +: DW] = 64'hDEAD; mem_req_ready_i = 1'b0;
    tick();
    req_addr_i[2*AW +: AW] = 64'h5678; req_wdata_i[2*DW +: DW] = 64'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_no_grant", req_ready_o, 0);
      chk("bp_addr_hold", mem_req_addr_o, 64'h1234);
      chk("bp_wdata_hold", mem_req_wdata_o, 64'hDEAD);
      tick();
    end
    mem_req_ready_i = 1'b1;
    #1 chk("bp_grant_on_accept", req_ready_o, 3'b100);
    tick();
    req_valid_i = '0;
    chk("bp_new_addr", mem_req_addr_o, 64'h5678);
    chk("bp_new_tid", mem_req_tid_o, 1);
    chk("bp_new_we", mem_req_we_o, 1);

    // Bogus response to free TID 3
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd3; mem_rsp_rdata_i = 64'h33;
    #1 chk("bogus_rsp_valid", rsp_valid_o, 0);
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("bogus_err", err_o, 1);
    chk("bogus_outstanding", outstanding_o, 2);
    tick();
    chk("bogus_err_sticky", err_o, 1);

    // Reset with two TIDs outstanding
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("midrst_outstanding", outstanding_o, 0);
    chk("midrst_valid", mem_req_valid_o, 0);
    chk("midrst_err", err_o, 0);
    req_valid_i = 3'b001; req_addr_i[0 +: AW] = 64'hABC;
    #1 chk("midrst_ready", req_ready_o, 3'b001);
    tick();
    req_valid_i = '0;
    chk("midrst_tid", mem_req_tid_o, 0);
    chk("midrst_addr", mem_req_addr_o, 64'hABC);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
